// File: rtl/maze_pg_if.sv
// Request handshake bundle for the mesh power-gate controller.
//   req_vld  : request valid (master -> slave)
//   req_on   : 1 = gate node, 0 = release gated node (master -> slave)
//   req_node : target node coordinate {vp[2:0],hp[2:0]} (master -> slave)
//   req_rdy  : controller can accept a request (slave -> master)
interface maze_pg_if #(
  parameter int ID_W = 6
);
  logic            req_vld;
  logic            req_on;
  logic [ID_W-1:0] req_node;
  logic            req_rdy;

  modport master (output req_vld, req_on, req_node, input req_rdy);
  modport slave  (input req_vld, req_on, req_node, output req_rdy);
endinterface

// File: rtl/maze_pg_ctrl.sv
// Mesh power-gate controller. Accepts gate/release requests for one node,
// drains the mesh (blocks injection until the network has been quiet for
// IDLE_CYC consecutive cycles), applies the new pg_en/pg_node, then waits
// WAKE_CYC settle cycles before signalling completion.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request handshake (slave side of maze_pg_if)
//   net_idle   : mesh quiescent this cycle (only observed while draining)
//   drain_o    : blocks new A-port injection at all nodes
//   pg_en      : fault/clock-gate enable to mesh top
//   pg_node    : gated node coordinate
//   done_o     : one-cycle pulse, operation completed
//   err_o      : one-cycle pulse, request rejected or drain timed out
// All outputs are registered.
module maze_pg_ctrl #(
  parameter int ID_W      = 6,
  parameter int IDLE_CYC  = 8,
  parameter int WAKE_CYC  = 4,
  parameter int DRAIN_TMO = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  maze_pg_if.slave        req,
  input  logic            net_idle,
  output logic            drain_o,
  output logic            pg_en,
  output logic [ID_W-1:0] pg_node,
  output logic            done_o,
  output logic            err_o
);

  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int TW = $clog2(DRAIN_TMO + 1);
  localparam int WW = $clog2(WAKE_CYC + 1);

  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(DRAIN_TMO - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_APPLY, S_SETTLE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idle_cnt, idle_nxt;
  logic [TW-1:0]     tmo_cnt, tmo_nxt;
  logic [WW-1:0]     wake_cnt, wake_nxt;
  logic              lat_on, lat_on_nxt;
  logic [ID_W-1:0]   lat_node, lat_node_nxt;
  logic              pg_en_nxt;
  logic [ID_W-1:0]   pg_node_nxt;
  logic              done_nxt, err_nxt;
  logic              rdy_q;
  logic              reject;

  assign req.req_rdy = rdy_q;

  // Gating while something is already gated, or releasing a node that is not
  // the gated one, is refused without touching any output.
  assign reject = req.req_on ? pg_en
                             : (!pg_en || (req.req_node != pg_node));

  always_comb begin
    state_nxt    = state;
    idle_nxt     = idle_cnt;
    tmo_nxt      = tmo_cnt;
    wake_nxt     = wake_cnt;
    lat_on_nxt   = lat_on;
    lat_node_nxt = lat_node;
    pg_en_nxt    = pg_en;
    pg_node_nxt  = pg_node;
    err_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        if (req.req_vld) begin
          if (reject) begin
            err_nxt = 1'b1;
          end else begin
            lat_on_nxt   = req.req_on;
            lat_node_nxt = req.req_node;
            idle_nxt     = '0;
            tmo_nxt      = '0;
            state_nxt    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        tmo_nxt  = tmo_cnt + 1'b1;
        idle_nxt = net_idle ? idle_cnt + 1'b1 : '0;
        // Quiet-window completion takes priority over the timeout.
        if (net_idle && (idle_cnt == IDLE_LAST)) begin
          state_nxt = S_APPLY;
          idle_nxt  = '0;
          tmo_nxt   = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
          idle_nxt  = '0;
          tmo_nxt   = '0;
        end
      end
      S_APPLY: begin
        pg_en_nxt = lat_on;
        if (lat_on) begin
          pg_node_nxt = lat_node;
        end
        wake_nxt  = '0;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (wake_cnt == WAKE_LAST) begin
          wake_nxt  = '0;
          state_nxt = S_IDLE;
        end else begin
          wake_nxt = wake_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // done_o is registered, so it is raised on the edge entering the last
    // settle cycle rather than during it.
    done_nxt = (state_nxt == S_SETTLE) && (wake_nxt == WAKE_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idle_cnt <= '0;
      tmo_cnt  <= '0;
      wake_cnt <= '0;
      lat_on   <= 1'b0;
      lat_node <= '0;
      pg_en    <= 1'b0;
      pg_node  <= '0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      drain_o  <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      tmo_cnt  <= tmo_nxt;
      wake_cnt <= wake_nxt;
      lat_on   <= lat_on_nxt;
      lat_node <= lat_node_nxt;
      pg_en    <= pg_en_nxt;
      pg_node  <= pg_node_nxt;
      done_o   <= done_nxt;
      err_o    <= err_nxt;
      drain_o  <= (state_nxt != S_IDLE);
      rdy_q    <= (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_maze_pg_ctrl.sv
// Self-checking bench for maze_pg_ctrl with default parameters.
// Expected done/err events are queued when a request is issued; a monitor
// pops and checks them whenever done_o or err_o fires.
module tb_maze_pg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       net_idle = 1'b1;
  logic       drain_o, pg_en, done_o, err_o;
  logic [5:0] pg_node;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit         is_done;
    int         at_cyc;
    bit         exp_en;
    logic [5:0] exp_node;
  } ev_t;

  ev_t sb[$];

  maze_pg_if #(.ID_W(6)) bus ();

  maze_pg_ctrl #(
    .ID_W(6), .IDLE_CYC(8), .WAKE_CYC(4), .DRAIN_TMO(1024)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.slave),
    .net_idle (net_idle),
    .drain_o  (drain_o),
    .pg_en    (pg_en),
    .pg_node  (pg_node),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (done_o || err_o)) begin
      chk("done_err_exclusive", 32'(done_o & err_o), 0);
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: done=%0b err=%0b expected none (cyc %0d)",
                 done_o, err_o, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_kind_done", 32'(done_o), 32'(e.is_done));
        chk("ev_cycle", cyc, e.at_cyc);
        chk("ev_pg_en", 32'(pg_en), 32'(e.exp_en));
        chk("ev_pg_node", 32'(pg_node), 32'(e.exp_node));
        chk("ev_drain", 32'(drain_o), e.is_done ? 1 : 0);
        chk("ev_req_rdy", 32'(bus.req_rdy), e.is_done ? 0 : 1);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue(input bit on, input logic [5:0] node, input bit push,
                       input bit is_done, input int dly, input bit exp_en,
                       input logic [5:0] exp_node, output int t);
    ev_t e;
    @(negedge clk);
    bus.req_vld  = 1'b1;
    bus.req_on   = on;
    bus.req_node = node;
    t = cyc;
    chk("accept_rdy", 32'(bus.req_rdy), 1);
    if (push) begin
      e.is_done  = is_done;
      e.at_cyc   = t + dly;
      e.exp_en   = exp_en;
      e.exp_node = exp_node;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.req_vld = 1'b0;
  endtask

  task automatic wait_sb_empty(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL event_timeout: %0d events pending expected 0 (cyc %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  initial begin
    int t;
    bus.req_vld  = 1'b0;
    bus.req_on   = 1'b0;
    bus.req_node = '0;

    repeat (3) @(negedge clk);
    chk("rst_drain", 32'(drain_o), 0);
    chk("rst_pg_en", 32'(pg_en), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_rdy", 32'(bus.req_rdy), 1);
    chk("rst_pg_node", 32'(pg_node), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);

    // Drain timeout: mesh never quiet.
    net_idle = 1'b0;
    issue(1'b1, 6'o33, 1'b1, 1'b0, 1025, 1'b0, 6'd0, t);
    wait_sb_empty(1200);
    net_idle = 1'b1;

    // Gate node 27 with a quiet mesh; a request while busy is ignored.
    issue(1'b1, 6'o33, 1'b1, 1'b1, 13, 1'b1, 6'd27, t);
    wait_cyc(t + 3);
    chk("busy_drain", 32'(drain_o), 1);
    chk("busy_rdy", 32'(bus.req_rdy), 0);
    bus.req_vld = 1'b1; bus.req_on = 1'b0; bus.req_node = 6'd27;
    @(negedge clk);
    bus.req_vld = 1'b0;
    wait_cyc(t + 9);
    chk("apply_pg_en_old", 32'(pg_en), 0);
    wait_cyc(t + 10);
    chk("gate_pg_en_new", 32'(pg_en), 1);
    chk("gate_pg_node_new", 32'(pg_node), 27);
    wait_cyc(t + 14);
    chk("post_rdy", 32'(bus.req_rdy), 1);
    chk("post_drain", 32'(drain_o), 0);
    wait_sb_empty(50);

    // Rejections while node 27 is gated.
    issue(1'b1, 6'd5, 1'b1, 1'b0, 1, 1'b1, 6'd27, t);
    wait_sb_empty(20);
    issue(1'b0, 6'd6, 1'b1, 1'b0, 1, 1'b1, 6'd27, t);
    wait_sb_empty(20);

    // Release node 27.
    issue(1'b0, 6'd27, 1'b1, 1'b1, 13, 1'b0, 6'd27, t);
    wait_cyc(t + 9);
    chk("rel_pg_en_old", 32'(pg_en), 1);
    wait_cyc(t + 10);
    chk("rel_pg_en_new", 32'(pg_en), 0);
    wait_sb_empty(50);

    // Quiet window broken at DRAIN cycle 5: completion slips by 5 cycles.
    issue(1'b1, 6'o33, 1'b1, 1'b1, 18, 1'b1, 6'd27, t);
    wait_cyc(t + 5);
    net_idle = 1'b0;
    wait_cyc(t + 6);
    net_idle = 1'b1;
    wait_cyc(t + 14);
    chk("toggle_pg_en_old", 32'(pg_en), 0);
    wait_cyc(t + 15);
    chk("toggle_pg_en_new", 32'(pg_en), 1);
    wait_sb_empty(50);

    issue(1'b0, 6'd27, 1'b1, 1'b1, 13, 1'b0, 6'd27, t);
    wait_sb_empty(50);

    // Reset during SETTLE discards the operation.
    issue(1'b1, 6'd9, 1'b0, 1'b0, 0, 1'b0, 6'd0, t);
    wait_cyc(t + 11);
    chk("settle_pg_en", 32'(pg_en), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pg_en", 32'(pg_en), 0);
    chk("midrst_drain", 32'(drain_o), 0);
    chk("midrst_pg_node", 32'(pg_node), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", 32'(bus.req_rdy), 1);
    repeat (20) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maze_pg_ctrl.md
MAZE_PG_CTRL -- requirements
Module: maze_pg_ctrl

Interface
REQ-001 Parameter ID_W, default 6, width of node coordinate {vp[2:0],hp[2:0]}.
REQ-002 Parameter IDLE_CYC, default 8, consecutive quiet cycles required before pg_en changes; legal range 1..255.
REQ-003 Parameter WAKE_CYC, default 4, settle cycles after pg_en changes; legal range 1..255.
REQ-004 Parameter DRAIN_TMO, default 1024, maximum DRAIN cycles before abort; must exceed IDLE_CYC.
REQ-005 clk  in  1  single clock for the block.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 req_vld  in  1  gate/release request valid.
REQ-008 req_on  in  1  1 = gate (fault) node, 0 = release gated node.
REQ-009 req_node  in  ID_W  target node coordinate.
REQ-010 req_rdy  out  1  request accepted when req_vld & req_rdy.
REQ-011 net_idle  in  1  mesh quiescent this cycle (no packet in flight on any C link or IRS).
REQ-012 drain_o  out  1  blocks new A-port injection at all nodes.
REQ-013 pg_en  out  1  fault/clock-gate enable to mesh top.
REQ-014 pg_node  out  ID_W  gated node coordinate.
REQ-015 done_o  out  1  one-cycle pulse, operation completed.
REQ-016 err_o  out  1  one-cycle pulse, request rejected or aborted.

Function
REQ-017 FSM states IDLE, DRAIN, APPLY, SETTLE; one-hot or encoded at implementer's choice.
REQ-018 req_rdy SHALL be 1 only in IDLE; drain_o SHALL be 1 in DRAIN, APPLY, SETTLE, else 0.
REQ-019 IDLE, accepted req with req_on=1 and pg_en=1: reject, err_o=1 next cycle, stay IDLE, no output change.
REQ-020 IDLE, accepted req with req_on=0 and (pg_en=0 or req_node!=pg_node): reject as REQ-019.
REQ-021 Otherwise accepted request SHALL latch req_on/req_node, clear idle_cnt and tmo_cnt, go DRAIN next cycle.
REQ-022 DRAIN: idle_cnt increments when net_idle=1, clears to 0 when net_idle=0; tmo_cnt increments every DRAIN cycle.
REQ-023 DRAIN -> APPLY when net_idle=1 and idle_cnt==IDLE_CYC-1 (i.e. IDLE_CYC consecutive quiet DRAIN cycles).
REQ-024 DRAIN -> IDLE when tmo_cnt==DRAIN_TMO-1 and REQ-023 not met; err_o=1 in first IDLE cycle; pg_en/pg_node unchanged.
REQ-025 Simultaneous REQ-023 and REQ-024 conditions: APPLY wins, no err_o.
REQ-026 APPLY lasts exactly one cycle; at its closing edge gate sets pg_en=1, pg_node=latched node; release sets pg_en=0, pg_node retained.
REQ-027 SETTLE lasts exactly WAKE_CYC cycles (counter wraps to 0 on exit); done_o=1 in last SETTLE cycle; next state IDLE.
REQ-028 net_idle is ignored outside DRAIN; req_vld is ignored when req_rdy=0.
REQ-029 Latency, net_idle held 1, accept at cycle T: DRAIN T+1..T+IDLE_CYC, APPLY T+IDLE_CYC+1, pg_en new value from T+IDLE_CYC+2, done_o at T+IDLE_CYC+WAKE_CYC+1, req_rdy=1 at T+IDLE_CYC+WAKE_CYC+2.
REQ-030 Counters sized to hold their parameter maximum; no counter SHALL wrap during DRAIN.
REQ-031 done_o and err_o SHALL never be high in the same cycle.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, req_rdy=1 after release, drain_o=0, pg_en=0, pg_node=0, done_o=0, err_o=0, all counters 0.
REQ-033 Reset mid-operation SHALL discard the pending request; no done_o/err_o for it after reset.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Gate node 27 (6'o33), net_idle=1, defaults, accept T=0 -> drain_o 1..13, pg_en=1 and pg_node=27 from 10, done_o at 13, req_rdy at 14.
REQ-036 Gate, net_idle toggles 0 at DRAIN cycle 5 -> idle_cnt restarts; APPLY 8 quiet cycles after toggle; done_o delayed by 5 cycles vs REQ-035.
REQ-037 Gate with net_idle=0 permanently -> err_o at cycle 1025, pg_en=0, drain_o=0, req_rdy=1.
REQ-038 With node 27 gated: gate node 5 -> err_o next cycle; release node 6 -> err_o; release node 27 -> pg_en=0 at cycle 10, done_o at 13.
REQ-039 rst_n asserted in SETTLE after pg_en=1 -> pg_en=0, drain_o=0 immediately; no done_o after reset release.
